// File: rtl/pwr_seq_pkg.sv
// Shared types and defaults for the board power-rail sequencer.
//   seq_state_e    : sequencer state encoding, also driven onto state_dbg_o
//   CNT_W_DEF      : default width of the per-rail delays and the shared timer
//   PG_TIMEOUT_DEF : default cycles allowed for a rail's power-good after enable
package pwr_seq_pkg;

    localparam int unsigned CNT_W_DEF      = 8;
    localparam int unsigned PG_TIMEOUT_DEF = 200;
    localparam int unsigned STATE_W        = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_UP_DLY = 3'd1,
        ST_UP_PG  = 3'd2,
        ST_ON     = 3'd3,
        ST_DN_DLY = 3'd4,
        ST_FAULT  = 3'd5
    } seq_state_e;

endpackage

// File: rtl/seq_delay_timer.sv
// Load-and-count-up timer shared by the pre-enable delays and the power-good timeout.
//   clk, rst_n : clock, synchronous active-low reset
//   load_i     : restart the count at 0 and capture target_i
//   target_i   : terminal count
//   done_o     : count has reached the target (holds there, no wrap)
module seq_delay_timer
    import pwr_seq_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] target_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] tgt_q;

    // Count saturates at the target so done stays asserted until the next load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tgt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
            tgt_q <= target_i;
        end else if (cnt_q != tgt_q) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign done_o = (cnt_q == tgt_q);

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Power-rail sequencer: brings NUM_RAILS rails up in order (rail 0 first), each after
// a programmable delay and a power-good check, and down in reverse order. A power-good
// failure drops every rail at once and latches a fault until fault_clr_i.
//   clk, rst_n    : clock, synchronous active-low reset
//   pwr_on_req_i  : level request, 1 = sequence up / stay on, 0 = sequence down
//   fault_clr_i   : pulse, clears a latched fault
//   rail_pg_i     : per-rail power-good (already synchronous)
//   dly_cfg_i     : per-rail pre-enable delay, rail i at [i*CNT_W +: CNT_W]
//   rail_en_o     : regulator enables
//   pwr_ok_o      : all rails up (ON state)
//   fault_o       : latched fault flag
//   fault_rail_o  : first failing rail index
//   state_dbg_o   : current state encoding
module pwr_seq_ctrl
    import pwr_seq_pkg::*;
#(
    parameter int unsigned NUM_RAILS  = 4,
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned PG_TIMEOUT = PG_TIMEOUT_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pwr_on_req_i,
    input  logic                         fault_clr_i,
    input  logic [NUM_RAILS-1:0]         rail_pg_i,
    input  logic [NUM_RAILS*CNT_W-1:0]   dly_cfg_i,
    output logic [NUM_RAILS-1:0]         rail_en_o,
    output logic                         pwr_ok_o,
    output logic                         fault_o,
    output logic [$clog2(NUM_RAILS)-1:0] fault_rail_o,
    output logic [STATE_W-1:0]           state_dbg_o
);

    localparam int unsigned IDX_W = $clog2(NUM_RAILS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RAILS - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    seq_state_e           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_RAILS-1:0] rail_en_q, rail_en_d;
    logic                 fault_q, fault_d;
    logic [IDX_W-1:0]     fault_rail_q, fault_rail_d;
    logic                 pwr_ok_q;

    logic                 tmr_load;
    logic [CNT_W-1:0]     tmr_target;
    logic                 tmr_done;

    logic [CNT_W-1:0]     dly_arr [NUM_RAILS];
    logic [IDX_W-1:0]     low_fail;

    seq_delay_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (tmr_load),
        .target_i (tmr_target),
        .done_o   (tmr_done)
    );

    // Unpack per-rail delays and find the lowest rail whose power-good is low.
    always_comb begin
        low_fail = '0;
        for (int r = 0; r < int'(NUM_RAILS); r++) begin
            dly_arr[r] = dly_cfg_i[r*CNT_W +: CNT_W];
        end
        for (int r = int'(NUM_RAILS) - 1; r >= 0; r--) begin
            if (!rail_pg_i[r]) begin
                low_fail = IDX_W'(r);
            end
        end
    end

    // Next-state, rail enable and timer control.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rail_en_d    = rail_en_q;
        fault_d      = fault_q;
        fault_rail_d = fault_rail_q;
        tmr_load     = 1'b0;
        tmr_target   = '0;

        case (state_q)
            ST_IDLE: begin
                rail_en_d = '0;
                if (pwr_on_req_i && !fault_q) begin
                    idx_d      = '0;
                    tmr_load   = 1'b1;
                    tmr_target = dly_arr[0];
                    state_d    = ST_UP_DLY;
                end
            end

            ST_UP_DLY: begin
                // Rails below idx are already on; abort unwinds from idx-1.
                if (!pwr_on_req_i) begin
                    if (idx_q == '0) begin
                        rail_en_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        idx_d      = idx_q - ONE_IDX;
                        tmr_load   = 1'b1;
                        tmr_target = dly_arr[idx_q - ONE_IDX];
                        state_d    = ST_DN_DLY;
                    end
                end else if (tmr_done) begin
                    rail_en_d[idx_q] = 1'b1;
                    tmr_load         = 1'b1;
                    tmr_target       = CNT_W'(PG_TIMEOUT);
                    state_d          = ST_UP_PG;
                end
            end

            ST_UP_PG: begin
                // Timeout fault outranks an abort; a good rail outranks the timeout.
                if (tmr_done && !rail_pg_i[idx_q]) begin
                    rail_en_d    = '0;
                    fault_d      = 1'b1;
                    fault_rail_d = idx_q;
                    state_d      = ST_FAULT;
                end else if (!pwr_on_req_i) begin
                    tmr_load   = 1'b1;
                    tmr_target = dly_arr[idx_q];
                    state_d    = ST_DN_DLY;
                end else if (rail_pg_i[idx_q]) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_ON;
                    end else begin
                        idx_d      = idx_q + ONE_IDX;
                        tmr_load   = 1'b1;
                        tmr_target = dly_arr[idx_q + ONE_IDX];
                        state_d    = ST_UP_DLY;
                    end
                end
            end

            ST_ON: begin
                if (rail_pg_i != '1) begin
                    rail_en_d    = '0;
                    fault_d      = 1'b1;
                    fault_rail_d = low_fail;
                    state_d      = ST_FAULT;
                end else if (!pwr_on_req_i) begin
                    idx_d      = LAST_IDX;
                    tmr_load   = 1'b1;
                    tmr_target = dly_arr[LAST_IDX];
                    state_d    = ST_DN_DLY;
                end
            end

            ST_DN_DLY: begin
                if (tmr_done) begin
                    rail_en_d[idx_q] = 1'b0;
                    if (idx_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d      = idx_q - ONE_IDX;
                        tmr_load   = 1'b1;
                        tmr_target = dly_arr[idx_q - ONE_IDX];
                    end
                end
            end

            ST_FAULT: begin
                rail_en_d = '0;
                if (fault_clr_i) begin
                    fault_d      = 1'b0;
                    fault_rail_d = '0;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                rail_en_d = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            rail_en_q    <= '0;
            fault_q      <= 1'b0;
            fault_rail_q <= '0;
            pwr_ok_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rail_en_q    <= rail_en_d;
            fault_q      <= fault_d;
            fault_rail_q <= fault_rail_d;
            pwr_ok_q     <= (state_d == ST_ON);
        end
    end

    assign rail_en_o    = rail_en_q;
    assign pwr_ok_o     = pwr_ok_q;
    assign fault_o      = fault_q;
    assign fault_rail_o = fault_rail_q;
    assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Scoreboard bench for pwr_seq_ctrl: stimulus pushes the expected output snapshots
// (with the cycle they must appear on) and a monitor compares every output change.
module tb_pwr_seq_ctrl;
    import pwr_seq_pkg::*;

    typedef struct packed {
        logic [3:0] en;
        logic       ok;
        logic       flt;
        logic [1:0] fr;
        logic [2:0] st;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        fclr;
    logic [3:0]  pg_echo = 4'h0;
    logic [3:0]  pg_kill;
    logic [3:0]  rail_pg;
    logic [31:0] dly_cfg;
    logic [3:0]  rail_en;
    logic        pwr_ok;
    logic        fault;
    logic [1:0]  fault_rail;
    logic [2:0]  state_dbg;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    int    exp_cyc_q [$];
    snap_t exp_s_q   [$];

    // Hand-derived power-up event tables: delays {3,2,1,0} and all-zero delays.
    int         up_t_a [9] = '{1, 2, 4, 6, 8, 11, 13, 17, 19};
    int         up_t_z [9] = '{1, 2, 4, 5, 7, 8, 10, 11, 13};
    logic [3:0] up_en  [9] = '{4'h0, 4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'hF, 4'hF};
    logic [2:0] up_st  [9] = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2, 3'd3};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) pg_echo <= rail_en;
    assign rail_pg = pg_echo & ~pg_kill;

    pwr_seq_ctrl #(
        .NUM_RAILS  (4),
        .CNT_W      (8),
        .PG_TIMEOUT (200)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwr_on_req_i (req),
        .fault_clr_i  (fclr),
        .rail_pg_i    (rail_pg),
        .dly_cfg_i    (dly_cfg),
        .rail_en_o    (rail_en),
        .pwr_ok_o     (pwr_ok),
        .fault_o      (fault),
        .fault_rail_o (fault_rail),
        .state_dbg_o  (state_dbg)
    );

    function automatic snap_t mk(logic [3:0] en, logic ok, logic flt, logic [1:0] fr, logic [2:0] st);
        snap_t s;
        s.en  = en;
        s.ok  = ok;
        s.flt = flt;
        s.fr  = fr;
        s.st  = st;
        return s;
    endfunction

    task automatic push(input int c, input snap_t s);
        exp_cyc_q.push_back(c);
        exp_s_q.push_back(s);
    endtask

    task automatic push_up(input int base, input int n, input bit zero_dly);
        for (int k = 0; k < n; k++) begin
            push(base + (zero_dly ? up_t_z[k] : up_t_a[k]),
                 mk(up_en[k], (k == 8), 1'b0, 2'd0, up_st[k]));
        end
    endtask

    task automatic at_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: every change of the output snapshot is one comparison.
    initial begin
        snap_t prev;
        snap_t cur;
        snap_t es;
        int    ec;
        prev = '1;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur = mk(rail_en, pwr_ok, fault, fault_rail, state_dbg);
                if (cur !== prev) begin
                    checks++;
                    if (exp_s_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output cyc=%0d got en=%h ok=%b flt=%b fr=%0d st=%0d",
                                 cyc, cur.en, cur.ok, cur.flt, cur.fr, cur.st);
                    end else begin
                        ec = exp_cyc_q.pop_front();
                        es = exp_s_q.pop_front();
                        if (cur !== es || (ec >= 0 && ec != cyc)) begin
                            errors++;
                            $display("FAIL output_event cyc=%0d got en=%h ok=%b flt=%b fr=%0d st=%0d required cyc=%0d en=%h ok=%b flt=%b fr=%0d st=%0d",
                                     cyc, cur.en, cur.ok, cur.flt, cur.fr, cur.st,
                                     ec, es.en, es.ok, es.flt, es.fr, es.st);
                        end
                    end
                    prev = cur;
                end
            end
        end
    end

    // Stimulus.
    initial begin
        int b;
        int c;
        snap_t zero;
        zero    = mk(4'h0, 1'b0, 1'b0, 2'd0, 3'd0);
        rst_n   = 1'b0;
        req     = 1'b0;
        fclr    = 1'b0;
        pg_kill = 4'h0;
        dly_cfg = {8'd3, 8'd2, 8'd1, 8'd0};
        push(-1, zero);
        @(negedge clk);
        at_cyc(2);
        mon_en = 1'b1;
        at_cyc(3);
        rst_n = 1'b1;

        // Full power-up.
        at_cyc(5);
        b   = cyc;
        req = 1'b1;
        push_up(b, 9, 1'b0);

        // Power-down in reverse order.
        at_cyc(b + 25);
        c   = cyc;
        req = 1'b0;
        push(c + 1,  mk(4'hF, 1'b0, 1'b0, 2'd0, 3'd4));
        push(c + 5,  mk(4'h7, 1'b0, 1'b0, 2'd0, 3'd4));
        push(c + 8,  mk(4'h3, 1'b0, 1'b0, 2'd0, 3'd4));
        push(c + 10, mk(4'h1, 1'b0, 1'b0, 2'd0, 3'd4));
        push(c + 11, zero);

        // Abort while waiting for rail 1 power-good.
        at_cyc(c + 20);
        b   = cyc;
        req = 1'b1;
        push_up(b, 4, 1'b0);
        at_cyc(b + 6);
        req = 1'b0;
        push(b + 7,  mk(4'h3, 1'b0, 1'b0, 2'd0, 3'd4));
        push(b + 9,  mk(4'h1, 1'b0, 1'b0, 2'd0, 3'd4));
        push(b + 10, zero);

        // Rail 2 never reports good: timeout fault, then clear.
        at_cyc(b + 20);
        b       = cyc;
        pg_kill = 4'b0100;
        req     = 1'b1;
        push_up(b, 6, 1'b0);
        push(b + 212, mk(4'h0, 1'b0, 1'b1, 2'd2, 3'd5));
        at_cyc(b + 215);
        req = 1'b0;
        at_cyc(b + 220);
        fclr = 1'b1;
        push(b + 221, zero);
        at_cyc(b + 221);
        fclr = 1'b0;
        at_cyc(b + 225);
        fclr = 1'b1;
        at_cyc(b + 226);
        fclr    = 1'b0;
        pg_kill = 4'h0;

        // In ON, rail 1 glitches low together with a request drop: fault wins.
        at_cyc(b + 235);
        b   = cyc;
        req = 1'b1;
        push_up(b, 9, 1'b0);
        at_cyc(b + 25);
        c       = cyc;
        req     = 1'b0;
        pg_kill = 4'b0010;
        push(c + 1, mk(4'h0, 1'b0, 1'b1, 2'd1, 3'd5));
        at_cyc(c + 1);
        pg_kill = 4'h0;
        at_cyc(c + 5);
        fclr = 1'b1;
        push(c + 6, zero);
        at_cyc(c + 6);
        fclr = 1'b0;

        // Reset while ON, then re-sequence with all delays zero.
        at_cyc(c + 10);
        b   = cyc;
        req = 1'b1;
        push_up(b, 9, 1'b0);
        at_cyc(b + 25);
        c       = cyc;
        rst_n   = 1'b0;
        dly_cfg = '0;
        push(c + 1, zero);
        push_up(c + 1, 9, 1'b1);
        at_cyc(c + 1);
        rst_n = 1'b1;

        at_cyc(c + 30);
        checks++;
        if (exp_s_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events outstanding=%0d required=0 next_cyc=%0d",
                     exp_s_q.size(), exp_cyc_q[0]);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
